// File: rtl/enemy_spawner.sv
// Enemy table: spawns on togenerate rising edge, scrolls left on tick, retires at x<STEP.
// Optional ENEMY_PENDING_EN: one-deep pending request served when a slot frees.
module enemy_spawner #(
    parameter int SLOTS   = 4,
    parameter int XW      = 10,
    parameter int SPAWN_X = 639,
    parameter int STEP    = 2,
    parameter int KINDW   = 2
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          tick,
    input  logic                          pause,
    input  logic                          togenerate,
    output logic [SLOTS-1:0]              enemy_valid,
    output logic [SLOTS*(XW+KINDW)-1:0]   enemy_data,
    output logic [3:0]                    enemy_count,
    output logic                          spawn_ack,
    output logic                          spawn_drop
);
    localparam int W  = XW + KINDW;
    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [SLOTS-1:0] valid, nv;
    logic [XW-1:0]    x  [SLOTS];
    logic [XW-1:0]    nx [SLOTS];
    logic [KINDW-1:0] kind [SLOTS];
    logic [KINDW-1:0] nk   [SLOTS];
    logic [7:0]       lfsr;
    logic             tg_q;
    logic             pending, npend;
    logic             req, alloc, free_any;
    logic [IW-1:0]    free_idx;
    logic             ack_n, drop_n;
    logic [3:0]       cnt_n;

    assign req = togenerate & ~tg_q;

    always_comb begin
        nv       = valid;
        nx       = x;
        nk       = kind;
        npend    = pending;
        alloc    = 1'b0;
        ack_n    = 1'b0;
        drop_n   = 1'b0;
        free_any = 1'b0;
        free_idx = '0;
        cnt_n    = '0;
        // Free slot is judged on the table as it stood before this edge.
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
        if (tick && !pause) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (valid[i]) begin
                    if (x[i] < XW'(STEP)) begin
                        nv[i] = 1'b0;
                        nx[i] = '0;
                    end else begin
                        nx[i] = x[i] - XW'(STEP);
                    end
                end
            end
        end
`ifdef ENEMY_PENDING_EN
        if (pending && free_any) begin
            alloc = 1'b1;
            npend = req;
        end else if (req) begin
            if (pending)       drop_n = 1'b1;
            else if (free_any) alloc  = 1'b1;
            else               npend  = 1'b1;
        end
`else
        npend = 1'b0;
        if (req) begin
            if (free_any) alloc  = 1'b1;
            else          drop_n = 1'b1;
        end
`endif
        if (alloc) begin
            nv[free_idx] = 1'b1;
            nx[free_idx] = XW'(SPAWN_X);
            nk[free_idx] = lfsr[KINDW-1:0];
            ack_n        = 1'b1;
        end
        for (int i = 0; i < SLOTS; i++) begin
            cnt_n = cnt_n + 4'(nv[i]);
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            valid       <= '0;
            lfsr        <= 8'hA5;
            tg_q        <= 1'b0;
            pending     <= 1'b0;
            enemy_count <= '0;
            spawn_ack   <= 1'b0;
            spawn_drop  <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                x[i]    <= '0;
                kind[i] <= '0;
            end
        end else begin
            valid       <= nv;
            lfsr        <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            tg_q        <= togenerate;
            pending     <= npend;
            enemy_count <= cnt_n;
            spawn_ack   <= ack_n;
            spawn_drop  <= drop_n;
            for (int i = 0; i < SLOTS; i++) begin
                x[i]    <= nx[i];
                kind[i] <= nk[i];
            end
        end
    end

    assign enemy_valid = valid;

    for (genvar g = 0; g < SLOTS; g++) begin : g_pack
        assign enemy_data[g*W +: W] = {kind[g], x[g]};
    end
endmodule

// File: tb/tb_enemy_spawner.sv
// Directed bench for enemy_spawner with a reference model feeding an expected-value queue.
// Build with ENEMY_PENDING_EN defined to exercise the pending variant.
module tb_enemy_spawner;
    localparam int SLOTS = 4;
    localparam int XW    = 10;
    localparam int KW    = 2;
    localparam int W     = XW + KW;
    localparam int SPX   = 639;
    localparam int STEP  = 2;

    logic clock = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic pause = 1'b0;
    logic togenerate = 1'b0;
    logic [SLOTS-1:0]   enemy_valid;
    logic [SLOTS*W-1:0] enemy_data;
    logic [3:0]         enemy_count;
    logic               spawn_ack;
    logic               spawn_drop;

    enemy_spawner dut (
        .clock(clock), .rst(rst), .tick(tick), .pause(pause),
        .togenerate(togenerate), .enemy_valid(enemy_valid),
        .enemy_data(enemy_data), .enemy_count(enemy_count),
        .spawn_ack(spawn_ack), .spawn_drop(spawn_drop)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [SLOTS-1:0]   v;
        logic [SLOTS*W-1:0] d;
        logic [3:0]         c;
        logic               a;
        logic               dr;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    logic [SLOTS-1:0] mv;
    logic [XW-1:0]    mx [SLOTS];
    logic [KW-1:0]    mk [SLOTS];
    logic [7:0]       ml;
    logic             mtg, mpend, ma, md;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mv = '0; ml = 8'hA5; mtg = 0; mpend = 0; ma = 0; md = 0;
        for (int i = 0; i < SLOTS; i++) begin mx[i] = '0; mk[i] = '0; end
    endtask

    task automatic model_edge();
        int fi;
        logic r;
        logic [7:0] kl;
        logic want;
        fi = -1;
        for (int i = 0; i < SLOTS; i++)
            if (!mv[i] && fi < 0) fi = i;
        r = togenerate && !mtg;
        mtg = togenerate;
        kl = ml;
        ml = {ml[6:0], ml[7] ^ ml[5] ^ ml[4] ^ ml[3]};
        ma = 0; md = 0; want = 0;
        if (tick && !pause)
            for (int i = 0; i < SLOTS; i++)
                if (mv[i]) begin
                    if (int'(mx[i]) < STEP) begin mv[i] = 0; mx[i] = 0; end
                    else mx[i] = XW'(int'(mx[i]) - STEP);
                end
`ifdef ENEMY_PENDING_EN
        if (mpend && fi >= 0) begin want = 1; mpend = r; end
        else if (r) begin
            if (mpend) md = 1;
            else if (fi >= 0) want = 1;
            else mpend = 1;
        end
`else
        if (r) begin
            if (fi >= 0) want = 1;
            else md = 1;
        end
`endif
        if (want) begin
            mv[fi] = 1; mx[fi] = XW'(SPX); mk[fi] = kl[KW-1:0]; ma = 1;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.v = mv; e.c = 4'($countones(mv)); e.a = ma; e.dr = md;
        for (int i = 0; i < SLOTS; i++) e.d[i*W +: W] = {mk[i], mx[i]};
        return e;
    endfunction

    task automatic cyc();
        exp_t e;
        model_edge();
        sbq.push_back(model_out());
        @(posedge clock);
        #1;
        e = sbq.pop_front();
        chk("valid", 64'(enemy_valid), 64'(e.v));
        chk("data", 64'(enemy_data), 64'(e.d));
        chk("count", 64'(enemy_count), 64'(e.c));
        chk("ack", 64'(spawn_ack), 64'(e.a));
        chk("drop", 64'(spawn_drop), 64'(e.dr));
    endtask

    task automatic run(int n, logic t, logic p, logic g);
        for (int i = 0; i < n; i++) begin
            tick = t; pause = p; togenerate = g;
            cyc();
        end
        tick = 0;
    endtask

    task automatic spawn();
        run(1, 0, 0, 1);
        run(1, 0, 0, 0);
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) begin
            run(1, 1, 0, 0);
            run(1, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        rst = 0; tick = 0; pause = 0; togenerate = 0;
        #1;
        model_reset();
        chk("rst_valid", 64'(enemy_valid), 0);
        chk("rst_data", 64'(enemy_data), 0);
        chk("rst_count", 64'(enemy_count), 0);
        chk("rst_ack", 64'(spawn_ack), 0);
        chk("rst_drop", 64'(spawn_drop), 0);
        #2;
        rst = 1;
    endtask

    function automatic logic [XW-1:0] xof(int s);
        return enemy_data[s*W +: XW];
    endfunction

    initial begin
        int acks;
        int waited;
        model_reset();
        @(posedge clock); #1;
        do_reset();

        // reset in the middle of activity, then LFSR seed shows in first kind
        spawn(); spawn(); spawn();
        chk("three_live", 64'(enemy_count), 3);
        do_reset();
        run(1, 0, 0, 1);
        chk("seed_kind", 64'(enemy_data[XW +: KW]), 64'(2'b01));
        run(1, 0, 0, 0);
        do_reset();

        // held level is a single request
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            run(1, 0, 0, 1);
            if (spawn_ack) acks++;
        end
        run(1, 0, 0, 0);
        chk("one_ack", 64'(acks), 1);
        chk("slot0_valid", 64'(enemy_valid), 64'(4'b0001));
        chk("slot0_x", 64'(xof(0)), 639);
        chk("count1", 64'(enemy_count), 1);

        // scroll to the left edge
        ticks(1);
        chk("x_after1", 64'(xof(0)), 637);
        ticks(318);
        chk("x_after319", 64'(xof(0)), 1);
        ticks(1);
        chk("retired_v", 64'(enemy_valid[0]), 0);
        chk("retired_x", 64'(xof(0)), 0);

        // full table
        do_reset();
        spawn(); ticks(3); spawn(); spawn(); spawn();
        chk("full", 64'(enemy_count), 4);
        run(1, 0, 0, 1);
`ifdef ENEMY_PENDING_EN
        chk("full_nodrop", 64'(spawn_drop), 0);
`else
        chk("full_drop", 64'(spawn_drop), 1);
`endif
        run(1, 0, 0, 0);
        chk("full_drop_1cyc", 64'(spawn_drop), 0);
        waited = 0;
        while (enemy_count == 4 && waited < 800) begin
            run(1, waited[0] ? 1'b0 : 1'b1, 0, 0);
            waited++;
        end
        chk("retire_seen", 64'(waited < 800), 1);
        run(1, 0, 0, 0);
`ifdef ENEMY_PENDING_EN
        chk("pend_ack", 64'(spawn_ack), 1);
        chk("pend_x", 64'(xof(0)), 639);
        chk("pend_cnt", 64'(enemy_count), 4);
`else
        chk("nopend_cnt", 64'(enemy_count), 3);
`endif

        // retire and request on the same edge
        do_reset();
        spawn();
        ticks(319);
        chk("s0_x1", 64'(xof(0)), 1);
        spawn(); spawn(); spawn();
        run(1, 1, 0, 1);
        chk("same_s0_free", 64'(enemy_valid[0]), 0);
`ifdef ENEMY_PENDING_EN
        chk("same_nodrop", 64'(spawn_drop), 0);
`else
        chk("same_drop", 64'(spawn_drop), 1);
`endif
        run(2, 0, 0, 0);

        // pause freezes scrolling but not spawning
        do_reset();
        spawn();
        run(5, 1, 1, 0);
        run(1, 1, 1, 1);
        chk("pause_ack", 64'(spawn_ack), 1);
        run(4, 1, 1, 0);
        chk("pause_x0", 64'(xof(0)), 639);
        chk("pause_x1", 64'(xof(1)), 639);
        run(1, 1, 0, 0);
        chk("unpause_x0", 64'(xof(0)), 637);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
